// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
// Shared definitions for the ALU sharing arbiter:
//   state_e      - sequencer state encoding (IDLE, EXEC, RESP)
//   ALU_*        - ALU operation-select codes 0..7
//   ALU_NOP_SEL  - select value driven whenever no operation is executing;
//                  it makes the ALU output zero.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] ALU_ADD     = 3'd0;
    localparam logic [2:0] ALU_AND     = 3'd1;
    localparam logic [2:0] ALU_XOR     = 3'd2;
    localparam logic [2:0] ALU_SLL     = 3'd3;
    localparam logic [2:0] ALU_SRA     = 3'd4;
    localparam logic [2:0] ALU_SUB     = 3'd5;
    localparam logic [2:0] ALU_ADDMASK = 3'd6;
    localparam logic [2:0] ALU_ZERO    = 3'd7;

    localparam logic [2:0] ALU_NOP_SEL = ALU_ZERO;

endpackage

// File: rtl/alu_rr_grant.sv
// alu_rr_grant
// Two-requester grant logic. Produces a one-hot (or all-zero) grant from
// the two request valids and the identity of the last granted requester.
// Configuration macro: ALU_ARB_FIXED_PRIO_EN
//   undefined (default): round-robin, the requester that did not win last
//                        time wins a tie.
//   defined            : requester 0 always wins a tie; last_grant_i is
//                        then not used.
// Ports:
//   valid0_i, valid1_i - requester valids
//   last_grant_i       - 0/1: requester granted most recently
//   grant0_o, grant1_o - one-hot grant, zero when nobody is valid
module alu_rr_grant (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic grant0_o,
    output logic grant1_o
);

    always_comb begin
        grant0_o = 1'b0;
        grant1_o = 1'b0;
        if (valid0_i && valid1_i) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant0_o = 1'b1;
`else
            // last_grant_i == 1 means requester 1 went last, so 0 wins.
            grant0_o = last_grant_i;
            grant1_o = ~last_grant_i;
`endif
        end else begin
            grant0_o = valid0_i;
            grant1_o = valid1_i;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Time-shares one ALU between the execute stage (requester 0) and the
// address/branch-target unit (requester 1). A request is accepted in IDLE,
// its operands drive the ALU for exactly one EXEC cycle, the result is
// registered and then held in RESP until the owning requester takes it.
// Configuration macro: ALU_ARB_FIXED_PRIO_EN (see alu_rr_grant).
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   reqN_valid/ready/rs1/rs2/sel  - request handshake and operation, N=0,1
//   respN_valid/ready             - response handshake, N=0,1
//   res_data, res_msb             - registered ALU result and MSB
//   alu_rs1, alu_rs2, alu_sel     - to the ALU inputs
//   alu_sal, alu_msb              - from the ALU outputs
//   op_count                      - completed operations since reset
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_rs1,
    input  logic [WIDTH-1:0] req0_rs2,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_rs1,
    input  logic [WIDTH-1:0] req1_rs2,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_msb,
    output logic [WIDTH-1:0] alu_rs1,
    output logic [WIDTH-1:0] alu_rs2,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_sal,
    input  logic             alu_msb,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [SEL_W-1:0] NOP_SEL = SEL_W'(ALU_NOP_SEL);

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] rs1_q,        rs1_d;
    logic [WIDTH-1:0] rs2_q,        rs2_d;
    logic [SEL_W-1:0] sel_q,        sel_d;
    logic             owner_q,      owner_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] res_data_q,   res_data_d;
    logic             res_msb_q,    res_msb_d;
    logic [CNT_W-1:0] op_count_q,   op_count_d;

    logic grant0;
    logic grant1;

    alu_rr_grant u_grant (
        .valid0_i    (req0_valid),
        .valid1_i    (req1_valid),
        .last_grant_i(last_grant_q),
        .grant0_o    (grant0),
        .grant1_o    (grant1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rs1_q        <= '0;
            rs2_q        <= '0;
            sel_q        <= NOP_SEL;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            res_data_q   <= '0;
            res_msb_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            sel_q        <= sel_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            res_data_q   <= res_data_d;
            res_msb_q    <= res_msb_d;
            op_count_q   <= op_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        sel_d        = sel_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        res_data_d   = res_data_q;
        res_msb_d    = res_msb_q;
        op_count_d   = op_count_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        // Idle ALU inputs select the zero op so its output stays quiet.
        alu_rs1      = '0;
        alu_rs2      = '0;
        alu_sel      = NOP_SEL;

        case (state_q)
            IDLE: begin
                // A grant is only ever raised for a valid requester, so
                // grant doubles as the accept condition.
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0) begin
                    rs1_d        = req0_rs1;
                    rs2_d        = req0_rs2;
                    sel_d        = req0_sel;
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                end else if (grant1) begin
                    rs1_d        = req1_rs1;
                    rs2_d        = req1_rs2;
                    sel_d        = req1_sel;
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                alu_rs1    = rs1_q;
                alu_rs2    = rs2_q;
                alu_sel    = sel_q;
                res_data_d = alu_sal;
                res_msb_d  = alu_msb;
                state_d    = RESP;
            end
            RESP: begin
                resp0_valid = ~owner_q;
                resp1_valid = owner_q;
                // Only the owner's ready can retire the result.
                if (owner_q ? resp1_ready : resp0_ready) begin
                    op_count_d = op_count_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign res_data = res_data_q;
    assign res_msb  = res_msb_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic [2:0]  req0_sel, req1_sel;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] res_data;
    logic        res_msb;
    logic [31:0] alu_rs1, alu_rs2, alu_sal;
    logic [2:0]  alu_sel;
    logic        alu_msb;
    logic [15:0] op_count;

    typedef struct {
        logic        who;
        logic [31:0] data;
        logic        msb;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_sel(req1_sel),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .res_data(res_data), .res_msb(res_msb),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_sel(alu_sel),
        .alu_sal(alu_sal), .alu_msb(alu_msb),
        .op_count(op_count)
    );

    // Reference ALU: used both as the device the arbiter drives and to
    // compute expected results from the requested operands.
    function automatic logic [31:0] ref_alu(input logic [2:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] sum;
        sum = a + b;
        case (sel)
            3'd0: return sum;
            3'd1: return a & b;
            3'd2: return a ^ b;
            3'd3: return a << b[4:0];
            3'd4: return $unsigned($signed(a) >>> b[4:0]);
            3'd5: return a - b;
            3'd6: return sum & 32'h0000_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        alu_sal = ref_alu(alu_sel, alu_rs1, alu_rs2);
        alu_msb = alu_sal[31];
    end

    function automatic exp_t mk_exp(input logic who, input logic [2:0] sel,
                                    input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.who  = who;
        e.data = ref_alu(sel, a, b);
        e.msb  = e.data[31];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        req0_rs1 = 0; req0_rs2 = 0; req0_sel = 0;
        req1_rs1 = 0; req1_rs2 = 0; req1_sel = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_handshake got=%b want=0000",
                     {req0_ready, req1_ready, resp0_valid, resp1_valid});
        end
        vectors++;
        if (res_data !== 32'h0 || res_msb !== 1'b0 || op_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_regs res_data=%h msb=%b op_count=%0d want 0/0/0",
                     res_data, res_msb, op_count);
        end
        vectors++;
        if (alu_sel !== 3'd7 || alu_rs1 !== 32'h0 || alu_rs2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_alu sel=%0d rs1=%h rs2=%h want 7/0/0",
                     alu_sel, alu_rs1, alu_rs2);
        end
    endtask

    task automatic test_add();
        exp_t e;
        do_reset();
        req0_rs1 = 32'd5; req0_rs2 = 32'd3; req0_sel = 3'd0;
        req0_valid = 1; resp0_ready = 1;
        #1;
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL add_accept ready0=%b ready1=%b want 1/0", req0_ready, req1_ready);
        end
        sb_q.push_back(mk_exp(0, req0_sel, req0_rs1, req0_rs2));
        step();                       // edge k: accepted, now EXEC
        req0_valid = 0;
        #1;
        vectors++;
        if (alu_sel !== 3'd0 || alu_rs1 !== 32'd5 || alu_rs2 !== 32'd3 || resp0_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL add_exec sel=%0d rs1=%h rs2=%h resp0=%b want 0/5/3/0",
                     alu_sel, alu_rs1, alu_rs2, resp0_valid);
        end
        step();                       // edge k+1: result captured, RESP
        e = sb_q.pop_front();
        vectors++;
        if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || res_data !== e.data || res_msb !== e.msb) begin
            miscompares++;
            $display("FAIL add_resp v0=%b v1=%b data=%h msb=%b want 1/0/%h/%b",
                     resp0_valid, resp1_valid, res_data, res_msb, e.data, e.msb);
        end
        $display("resp owner=0 data=%h msb=%b", res_data, res_msb);
        vectors++;
        if (alu_sel !== 3'd7) begin
            miscompares++;
            $display("FAIL add_alu_idle sel=%0d want 7", alu_sel);
        end
        step();                       // edge k+2: response taken
        vectors++;
        if (resp0_valid !== 1'b0 || op_count !== 16'd1) begin
            miscompares++;
            $display("FAIL add_done resp0=%b op_count=%0d want 0/1", resp0_valid, op_count);
        end
    endtask

    task automatic test_tie_sub();
        exp_t e;
        do_reset();
        req0_rs1 = 32'd1; req0_rs2 = 32'd1; req0_sel = 3'd0;
        req1_rs1 = 32'd3; req1_rs2 = 32'd5; req1_sel = 3'd5;
        req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
        #1;
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_first ready0=%b ready1=%b want 1/0", req0_ready, req1_ready);
        end
        sb_q.push_back(mk_exp(0, req0_sel, req0_rs1, req0_rs2));
        step();
        req0_valid = 0;
        #1;
        vectors++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_exec_ready ready0=%b ready1=%b want 0/0", req0_ready, req1_ready);
        end
        step();
        e = sb_q.pop_front();
        vectors++;
        if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || res_data !== e.data || res_data !== 32'd2) begin
            miscompares++;
            $display("FAIL tie_resp0 v0=%b v1=%b data=%h want 1/0/00000002",
                     resp0_valid, resp1_valid, res_data);
        end
        $display("resp owner=0 data=%h msb=%b", res_data, res_msb);
        step();                       // back in IDLE, req1 still waiting
        vectors++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_second ready0=%b ready1=%b want 0/1", req0_ready, req1_ready);
        end
        sb_q.push_back(mk_exp(1, req1_sel, req1_rs1, req1_rs2));
        step();
        req1_valid = 0;
        step();
        e = sb_q.pop_front();
        vectors++;
        if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || res_data !== e.data ||
            res_data !== 32'hFFFF_FFFE || res_msb !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_resp1 v0=%b v1=%b data=%h msb=%b want 0/1/fffffffe/1",
                     resp0_valid, resp1_valid, res_data, res_msb);
        end
        $display("resp owner=1 data=%h msb=%b", res_data, res_msb);
        step();
        vectors++;
        if (op_count !== 16'd2 || resp1_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_count op_count=%0d resp1=%b want 2/0", op_count, resp1_valid);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   acc_who[4];
        int   acc_cyc[4];
        int   want_who[4];
        int   accepts;
        int   cyc;
`ifdef ALU_ARB_FIXED_PRIO_EN
        want_who = '{0, 0, 0, 0};
`else
        want_who = '{0, 1, 0, 1};
`endif
        do_reset();
        req0_rs1 = 32'hF0F0_1234; req0_rs2 = 32'h0FF0_00FF; req0_sel = 3'd2;
        req1_rs1 = 32'h8000_0003; req1_rs2 = 32'd4;         req1_sel = 3'd4;
        resp0_ready = 1; resp1_ready = 1;
        accepts = 0;
        cyc = 0;
        while ((accepts < 4 || sb_q.size() != 0) && cyc < 40) begin
            req0_valid = (accepts < 4);
            req1_valid = (accepts < 4);
            #1;
            if (req0_ready && req1_ready) begin
                vectors++;
                miscompares++;
                $display("FAIL rr_both_ready cyc=%0d got=11 want one-hot", cyc);
            end
            if (req0_valid && req0_ready) begin
                acc_who[accepts] = 0; acc_cyc[accepts] = cyc; accepts++;
                sb_q.push_back(mk_exp(0, req0_sel, req0_rs1, req0_rs2));
            end else if (req1_valid && req1_ready) begin
                acc_who[accepts] = 1; acc_cyc[accepts] = cyc; accepts++;
                sb_q.push_back(mk_exp(1, req1_sel, req1_rs1, req1_rs2));
            end
            if (resp0_valid || resp1_valid) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rr_unexpected_resp v0=%b v1=%b want none", resp0_valid, resp1_valid);
                end else begin
                    e = sb_q.pop_front();
                    if (resp1_valid !== e.who || resp0_valid !== ~e.who ||
                        res_data !== e.data || res_msb !== e.msb) begin
                        miscompares++;
                        $display("FAIL rr_resp v0=%b v1=%b data=%h msb=%b want owner=%0d data=%h msb=%b",
                                 resp0_valid, resp1_valid, res_data, res_msb, e.who, e.data, e.msb);
                    end
                    $display("resp owner=%0d data=%h msb=%b", resp1_valid, res_data, res_msb);
                end
            end
            step();
            cyc++;
        end
        req0_valid = 0; req1_valid = 0;
        vectors++;
        if (cyc >= 40 || accepts != 4) begin
            miscompares++;
            $display("FAIL rr_timeout accepts=%0d pending=%0d want 4/0", accepts, sb_q.size());
        end
        for (int i = 0; i < accepts; i++) begin
            vectors++;
            if (acc_who[i] != want_who[i] || (i > 0 && acc_cyc[i] - acc_cyc[i-1] != 3)) begin
                miscompares++;
                $display("FAIL rr_order op=%0d who=%0d gap=%0d want who=%0d gap=3",
                         i, acc_who[i], (i > 0) ? acc_cyc[i] - acc_cyc[i-1] : 0, want_who[i]);
            end
        end
        #1;
        vectors++;
        if (op_count !== 16'd4) begin
            miscompares++;
            $display("FAIL rr_count op_count=%0d want 4", op_count);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        do_reset();
        req1_rs1 = 32'h0001_2345; req1_rs2 = 32'd1; req1_sel = 3'd6;
        req1_valid = 1; resp1_ready = 0; resp0_ready = 1;
        #1;
        sb_q.push_back(mk_exp(1, req1_sel, req1_rs1, req1_rs2));
        step();                       // accepted
        req1_valid = 0;
        req0_valid = 1;               // must not be accepted while busy
        req0_rs1 = 32'd7; req0_rs2 = 32'd7; req0_sel = 3'd1;
        step();                       // RESP
        e = sb_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || res_data !== e.data ||
                res_data !== 32'h0000_2346 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold cyc=%0d v1=%b v0=%b data=%h rdy=%b%b want 1/0/00002346/00",
                         i, resp1_valid, resp0_valid, res_data, req0_ready, req1_ready);
            end
            step();
        end
        resp1_ready = 1;
        #1;
        $display("resp owner=1 data=%h msb=%b", res_data, res_msb);
        step();
        resp1_ready = 0;
        #1;
        vectors++;
        if (resp1_valid !== 1'b0 || op_count !== 16'd1 || req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release v1=%b op_count=%0d ready0=%b want 0/1/1",
                     resp1_valid, op_count, req0_ready);
        end
        req0_valid = 0;
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        do_reset();
        req0_rs1 = 32'd2; req0_rs2 = 32'd2; req0_sel = 3'd0;
        req0_valid = 1; resp0_ready = 1;
        #1;
        sb_q.push_back(mk_exp(0, req0_sel, req0_rs1, req0_rs2));
        step();
        req0_valid = 0;
        step();
        e = sb_q.pop_front();
        vectors++;
        if (resp0_valid !== 1'b1 || res_data !== e.data) begin
            miscompares++;
            $display("FAIL mid_first v0=%b data=%h want 1/%h", resp0_valid, res_data, e.data);
        end
        $display("resp owner=0 data=%h msb=%b", res_data, res_msb);
        step();
        req0_rs1 = 32'd9; req0_rs2 = 32'd4; req0_sel = 3'd5;
        req0_valid = 1;
        step();                       // accepted, EXEC
        req0_valid = 0;
        #1;
        vectors++;
        if (alu_sel !== 3'd5 || op_count !== 16'd1) begin
            miscompares++;
            $display("FAIL mid_exec sel=%0d op_count=%0d want 5/1", alu_sel, op_count);
        end
        rst = 1;
        step();
        rst = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || res_data !== 32'h0 ||
                op_count !== 16'h0 || alu_sel !== 3'd7) begin
                miscompares++;
                $display("FAIL mid_reset cyc=%0d v=%b%b data=%h op_count=%0d sel=%0d want 00/0/0/7",
                         i, resp0_valid, resp1_valid, res_data, op_count, alu_sel);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_tie_sub();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
